// File: rtl/to_upper.sv
// Registered ASCII lowercase-to-uppercase converter on a bit-level byte bus, 1-cycle latency.
// Optional conversion counter (conv_cnt) is built only when TO_UPPER_COUNT_EN is defined.
module to_upper #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A0,
  input  logic             A1,
  input  logic             A2,
  input  logic             A3,
  input  logic             A4,
  input  logic             A5,
  input  logic             A6,
  input  logic             A7,
  input  logic             in_valid,
  output logic             B0,
  output logic             B1,
  output logic             B2,
  output logic             B3,
  output logic             B4,
  output logic             B5,
  output logic             B6,
  output logic             B7,
  output logic             out_valid,
  output logic             converted
`ifdef TO_UPPER_COUNT_EN
  ,
  output logic [CNT_W-1:0] conv_cnt
`endif
);

  logic [7:0] w_a;
  logic       w_lower;
  logic [7:0] w_y;
  logic [7:0] r_b;
  logic       r_out_valid;
  logic       r_converted;

  assign w_a = {A7, A6, A5, A4, A3, A2, A1, A0};

  // Full 8-bit range compare: bytes with bit 7 set must never fold.
  assign w_lower = (w_a >= 8'h61) && (w_a <= 8'h7A);
  assign w_y     = w_lower ? (w_a & 8'hDF) : w_a;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and wins over in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_b         <= 8'h00;
      r_out_valid <= 1'b0;
      r_converted <= 1'b0;
    end else if (in_valid) begin
      r_b         <= w_y;
      r_out_valid <= 1'b1;
      r_converted <= w_lower;
    end else begin
      r_out_valid <= 1'b0;
      r_converted <= 1'b0;
    end
  end

  assign {B7, B6, B5, B4, B3, B2, B1, B0} = r_b;
  assign out_valid = r_out_valid;
  assign converted = r_converted;

`ifdef TO_UPPER_COUNT_EN
  logic [CNT_W-1:0] r_conv_cnt;

  // Free-running modulo-2^CNT_W count of accepted lowercase bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_conv_cnt <= '0;
    end else if (in_valid && w_lower) begin
      r_conv_cnt <= r_conv_cnt + CNT_W'(1);
    end
  end

  assign conv_cnt = r_conv_cnt;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_to_upper.sv
// Self-checking bench for to_upper: reset, vector table, corner sequences, and
// randomized traffic against an arithmetic reference model.
module tb_to_upper;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic       in_valid;
  logic [7:0] b;
  logic       out_valid;
  logic       converted;
  logic B0, B1, B2, B3, B4, B5, B6, B7;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  logic [7:0] m_b;
  logic       m_v;
  logic       m_c;
  int         m_cnt;

  assign b = {B7, B6, B5, B4, B3, B2, B1, B0};

`ifdef TO_UPPER_COUNT_EN
  logic [15:0] conv_cnt;
  logic [1:0]  conv_cnt2;
  logic B0_2, B1_2, B2_2, B3_2, B4_2, B5_2, B6_2, B7_2, out_valid_2, converted_2;
`endif

  to_upper #(.CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
    .A4(a[4]), .A5(a[5]), .A6(a[6]), .A7(a[7]),
    .in_valid(in_valid),
    .B0(B0), .B1(B1), .B2(B2), .B3(B3), .B4(B4), .B5(B5), .B6(B6), .B7(B7),
    .out_valid(out_valid), .converted(converted)
`ifdef TO_UPPER_COUNT_EN
    , .conv_cnt(conv_cnt)
`endif
  );

`ifdef TO_UPPER_COUNT_EN
  // Narrow-counter instance to exercise wrap-around.
  to_upper #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]),
    .A4(a[4]), .A5(a[5]), .A6(a[6]), .A7(a[7]),
    .in_valid(in_valid),
    .B0(B0_2), .B1(B1_2), .B2(B2_2), .B3(B3_2), .B4(B4_2), .B5(B5_2), .B6(B6_2), .B7(B7_2),
    .out_valid(out_valid_2), .converted(converted_2),
    .conv_cnt(conv_cnt2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic       v;
    logic [7:0] exp_b;
    logic       exp_valid;
    logic       exp_conv;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle, let the DUT clock it, advance the model, sample #1 after the edge.
  task automatic step(input logic [7:0] ai, input logic vi, input logic ri);
    logic [7:0] ch;
    bit         lc;
    @(negedge clk);
    a        = ai;
    in_valid = vi;
    rst_n    = ri;
    @(posedge clk);
    ch = ai;
    lc = (ch >= "a") && (ch <= "z");
    if (!ri) begin
      m_b = 8'h00; m_v = 1'b0; m_c = 1'b0; m_cnt = 0;
    end else if (vi) begin
      m_b = lc ? ch - 8'd32 : ch;
      m_v = 1'b1;
      m_c = lc;
      m_cnt += int'(lc);
    end else begin
      m_v = 1'b0; m_c = 1'b0;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_b"}, 32'(b), 32'(m_b));
    check({tag, "_valid"}, 32'(out_valid), 32'(m_v));
    check({tag, "_conv"}, 32'(converted), 32'(m_c));
`ifdef TO_UPPER_COUNT_EN
    check({tag, "_cnt"}, 32'(conv_cnt), 32'(m_cnt % 65536));
    check({tag, "_cnt2"}, 32'(conv_cnt2), 32'(m_cnt % 4));
`endif
  endtask

  vec_t vecs[$];

  initial begin
    a = 8'h61; in_valid = 1'b1; rst_n = 1'b0;
    m_b = '0; m_v = 1'b0; m_c = 1'b0; m_cnt = 0;

    // Reset held two cycles while a lowercase byte is offered.
    for (int i = 0; i < 2; i++) begin
      step(8'h61, 1'b1, 1'b0);
      check($sformatf("reset%0d_b", i), 32'(b), 32'h00);
      check($sformatf("reset%0d_valid", i), 32'(out_valid), 32'h0);
      check($sformatf("reset%0d_conv", i), 32'(converted), 32'h0);
`ifdef TO_UPPER_COUNT_EN
      check($sformatf("reset%0d_cnt", i), 32'(conv_cnt), 32'h0);
`endif
    end

    vecs = '{
      '{8'h61, 1'b1, 8'h41, 1'b1, 1'b1},
      '{8'h7A, 1'b1, 8'h5A, 1'b1, 1'b1},
      '{8'h6D, 1'b1, 8'h4D, 1'b1, 1'b1},
      '{8'h60, 1'b1, 8'h60, 1'b1, 1'b0},
      '{8'h7B, 1'b1, 8'h7B, 1'b1, 1'b0},
      '{8'h7F, 1'b1, 8'h7F, 1'b1, 1'b0},
      '{8'h41, 1'b1, 8'h41, 1'b1, 1'b0},
      '{8'h47, 1'b1, 8'h47, 1'b1, 1'b0},
      '{8'h28, 1'b1, 8'h28, 1'b1, 1'b0},
      '{8'h30, 1'b1, 8'h30, 1'b1, 1'b0},
      '{8'h3A, 1'b1, 8'h3A, 1'b1, 1'b0},
      '{8'h14, 1'b1, 8'h14, 1'b1, 1'b0},
      '{8'h7C, 1'b1, 8'h7C, 1'b1, 1'b0},
      '{8'hEB, 1'b1, 8'hEB, 1'b1, 1'b0},
      '{8'h83, 1'b1, 8'h83, 1'b1, 1'b0},
      '{8'hCF, 1'b1, 8'hCF, 1'b1, 1'b0},
      '{8'h92, 1'b1, 8'h92, 1'b1, 1'b0},
      '{8'hE1, 1'b1, 8'hE1, 1'b1, 1'b0},
      '{8'h61, 1'b1, 8'h41, 1'b1, 1'b1},
      '{8'h33, 1'b0, 8'h41, 1'b0, 1'b0},
      '{8'h62, 1'b0, 8'h41, 1'b0, 1'b0}
    };
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].v, 1'b1);
      check($sformatf("vec%0d_b", i), 32'(b), 32'(vecs[i].exp_b));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_conv", i), 32'(converted), 32'(vecs[i].exp_conv));
    end

    // Mid-stream reset drops the byte in flight; no pulse after release.
    step(8'h62, 1'b1, 1'b1);
    check("midrst_pre_b", 32'(b), 32'h42);
    step(8'h63, 1'b1, 1'b0);
    check("midrst_b", 32'(b), 32'h00);
    check("midrst_valid", 32'(out_valid), 32'h0);
    step(8'h64, 1'b0, 1'b1);
    check("midrst_post_valid", 32'(out_valid), 32'h0);
    check("midrst_post_b", 32'(b), 32'h00);

`ifdef TO_UPPER_COUNT_EN
    // Counter: only genuine lowercase bytes count.
    step(8'h00, 1'b0, 1'b0);
    step(8'h61, 1'b1, 1'b1);
    step(8'h41, 1'b1, 1'b1);
    step(8'h7A, 1'b1, 1'b1);
    step(8'hE1, 1'b1, 1'b1);
    check("cnt_mix", 32'(conv_cnt), 32'd2);
    // Five lowercase bytes: narrow counter wraps to 1.
    step(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(8'h61 + 8'(i), 1'b1, 1'b1);
    check("cnt_five", 32'(conv_cnt), 32'd5);
    check("cnt2_wrap", 32'(conv_cnt2), 32'd1);
`endif

    // Randomized traffic against the model; lowercase range weighted up.
    step(8'h00, 1'b0, 1'b0);
    check_model("rnd_reset");
    for (int i = 0; i < 400; i++) begin
      logic [7:0] ra;
      ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(8'h5E, 8'h7F)) : 8'($urandom);
      step(ra, ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) != 0));
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
